// File: rtl/sys_rst_pkg.sv
// Shared types and helpers for the shell reset sequencer.
// The FSM encoding is fixed here so debug tooling can decode the exposed state.
package sys_rst_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SOFT_HOLD = 3'd4
  } rst_seq_state_t;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for a filtered clock lock, then releases stage resets in
// ascending order; supports masked soft re-reset and drops everything on lock loss.
module rst_seq_ctrl
  import sys_rst_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DLY   = 16,
  parameter int LOCK_FILTER = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dcm_locked,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] soft_rst_mask,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int LOCK_W = cnt_w(LOCK_FILTER);
  localparam int DLY_W  = cnt_w(STAGE_DLY);
  localparam int IDX_W  = cnt_w(NUM_STAGES);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILTER - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0]  IDX_SAT   = IDX_W'(NUM_STAGES);

  rst_seq_state_t         state_q;
  logic [LOCK_W-1:0]      lock_cnt_q;
  logic [DLY_W-1:0]       dly_cnt_q;
  logic [IDX_W-1:0]       stage_idx_q;
  logic [NUM_STAGES-1:0]  stage_rst_n_q;
  logic                   seq_done_q;
  logic                   busy_q;
  logic                   locked_s;
  logic [NUM_STAGES-1:0]  rel_mask;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (dcm_locked),
    .q_o (locked_s)
  );

  // OR-ing the one-hot bit in keeps stages that were never masked high.
  assign rel_mask = NUM_STAGES'(1) << stage_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HOLD;
      lock_cnt_q    <= '0;
      dly_cnt_q     <= '0;
      stage_idx_q   <= '0;
      stage_rst_n_q <= '0;
      seq_done_q    <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          stage_rst_n_q <= '0;
          seq_done_q    <= 1'b0;
          busy_q        <= 1'b1;
          lock_cnt_q    <= '0;
          dly_cnt_q     <= '0;
          stage_idx_q   <= '0;
          state_q       <= WAIT_LOCK;
        end

        WAIT_LOCK: begin
          if (!locked_s) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            lock_cnt_q  <= '0;
            dly_cnt_q   <= '0;
            stage_idx_q <= '0;
            state_q     <= RELEASE;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end

        RELEASE: begin
          if (!locked_s) begin
            state_q       <= HOLD;
            stage_rst_n_q <= '0;
            seq_done_q    <= 1'b0;
            busy_q        <= 1'b1;
            lock_cnt_q    <= '0;
            dly_cnt_q     <= '0;
            stage_idx_q   <= '0;
          end else if (dly_cnt_q == DLY_LAST) begin
            stage_rst_n_q <= stage_rst_n_q | rel_mask;
            dly_cnt_q     <= '0;
            if (stage_idx_q != IDX_SAT) begin
              stage_idx_q <= stage_idx_q + 1'b1;
            end
            if (stage_idx_q == IDX_LAST) begin
              state_q    <= RUN;
              seq_done_q <= 1'b1;
              busy_q     <= 1'b0;
            end
          end else begin
            dly_cnt_q <= dly_cnt_q + 1'b1;
          end
        end

        RUN: begin
          // Lock loss outranks a simultaneous soft request.
          if (!locked_s) begin
            state_q       <= HOLD;
            stage_rst_n_q <= '0;
            seq_done_q    <= 1'b0;
            busy_q        <= 1'b1;
            lock_cnt_q    <= '0;
            dly_cnt_q     <= '0;
            stage_idx_q   <= '0;
          end else if (soft_rst_req && (soft_rst_mask != '0)) begin
            stage_rst_n_q <= stage_rst_n_q & ~soft_rst_mask;
            seq_done_q    <= 1'b0;
            busy_q        <= 1'b1;
            dly_cnt_q     <= '0;
            state_q       <= SOFT_HOLD;
          end
        end

        SOFT_HOLD: begin
          if (!locked_s) begin
            state_q       <= HOLD;
            stage_rst_n_q <= '0;
            seq_done_q    <= 1'b0;
            busy_q        <= 1'b1;
            lock_cnt_q    <= '0;
            dly_cnt_q     <= '0;
            stage_idx_q   <= '0;
          end else if (dly_cnt_q == DLY_LAST) begin
            dly_cnt_q   <= '0;
            stage_idx_q <= '0;
            state_q     <= RELEASE;
          end else begin
            dly_cnt_q <= dly_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q       <= HOLD;
          stage_rst_n_q <= '0;
          seq_done_q    <= 1'b0;
          busy_q        <= 1'b1;
          lock_cnt_q    <= '0;
          dly_cnt_q     <= '0;
          stage_idx_q   <= '0;
        end
      endcase
    end
  end

  assign stage_rst_n = stage_rst_n_q;
  assign seq_done    = seq_done_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: output changes are matched in order against an
// expected queue of {edge, stage_rst_n, seq_done, busy} records.
module tb_rst_seq_ctrl;
  import sys_rst_pkg::*;

  localparam int NS = 3;
  localparam int SD = 4;
  localparam int LF = 8;
  localparam int W  = 16 + NS + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dcm_locked = 1'b1;
  logic          soft_rst_req = 1'b0;
  logic [NS-1:0] soft_rst_mask = '0;
  logic [NS-1:0] stage_rst_n;
  logic          seq_done;
  logic          busy;
  logic [2:0]    dbg_state;

  int            pass_cnt = 0;
  int            chk_cnt  = 0;
  int            edge_cnt = 0;
  logic [NS+1:0] prev_obs = 5'b00001;
  logic [W-1:0]  exp_q[$];

  rst_seq_ctrl #(
    .NUM_STAGES  (NS),
    .STAGE_DLY   (SD),
    .LOCK_FILTER (LF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dcm_locked    (dcm_locked),
    .soft_rst_req  (soft_rst_req),
    .soft_rst_mask (soft_rst_mask),
    .stage_rst_n   (stage_rst_n),
    .seq_done      (seq_done),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk_ev(input int e, input logic [NS-1:0] s,
                                         input logic d, input logic b);
    logic [15:0] e16;
    e16 = 16'(e);
    return {e16, s, d, b};
  endfunction

  // Stage k releases LF + 2 + (k+1)*SD edges after the lock is seen (14, 18, 22).
  task automatic push_powerup(input int base);
    exp_q.push_back(mk_ev(base + LF + 2 + 1 * SD, 3'b001, 1'b0, 1'b1));
    exp_q.push_back(mk_ev(base + LF + 2 + 2 * SD, 3'b011, 1'b0, 1'b1));
    exp_q.push_back(mk_ev(base + LF + 2 + 3 * SD, 3'b111, 1'b1, 1'b0));
  endtask

  // Advance n edges, sampling 1ns after each; every output change consumes one record.
  task automatic run_edges(input int n);
    logic [NS+1:0] obs;
    logic [W-1:0]  got;
    logic [W-1:0]  exp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_cnt++;
      obs = {stage_rst_n, seq_done, busy};
      if (obs !== prev_obs) begin
        chk_cnt++;
        got = {16'(edge_cnt), obs};
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change edge=%0d obs=%b required=no change", edge_cnt, obs);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp)
            $display("FAIL output_event got edge=%0d obs=%b required edge=%0d obs=%b",
                     got[W-1:NS+2], got[NS+1:0], exp[W-1:NS+2], exp[NS+1:0]);
          else
            pass_cnt++;
        end
        prev_obs = obs;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    edge_cnt = 0;
    prev_obs = 5'b00001;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    chk_cnt++;
    if (stage_rst_n !== 3'b000) $display("FAIL reset_stage got=%b required=000", stage_rst_n);
    else pass_cnt++;
    chk_cnt++;
    if (seq_done !== 1'b0) $display("FAIL reset_seq_done got=%b required=0", seq_done);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL reset_busy got=%b required=1", busy);
    else pass_cnt++;
    chk_cnt++;
    if (dbg_state !== HOLD) $display("FAIL reset_state got=%0d required=%0d", dbg_state, HOLD);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    edge_cnt = 0;
    prev_obs = 5'b00001;
  endtask

  task automatic test_powerup();
    push_powerup(0);
    run_edges(26);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL powerup_missing got=%0d pending required=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
    chk_cnt++;
    if (dbg_state !== RUN) $display("FAIL powerup_state got=%0d required=%0d", dbg_state, RUN);
    else pass_cnt++;
  endtask

  task automatic test_soft_reset();
    // Request accepted at edge 1 (E); stage 1 back at E+12, RUN again at E+16.
    edge_cnt = 0;
    exp_q.push_back(mk_ev(1, 3'b101, 1'b0, 1'b1));
    exp_q.push_back(mk_ev(1 + 3 * SD, 3'b111, 1'b0, 1'b1));
    exp_q.push_back(mk_ev(1 + 4 * SD, 3'b111, 1'b1, 1'b0));
    soft_rst_req  = 1'b1;
    soft_rst_mask = 3'b010;
    run_edges(1);
    soft_rst_req  = 1'b0;
    soft_rst_mask = '0;
    chk_cnt++;
    if (dbg_state !== SOFT_HOLD) $display("FAIL soft_state got=%0d required=%0d", dbg_state, SOFT_HOLD);
    else pass_cnt++;
    run_edges(20);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL soft_missing got=%0d pending required=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_soft_ignored();
    edge_cnt = 0;
    soft_rst_req  = 1'b1;
    soft_rst_mask = '0;
    run_edges(1);
    soft_rst_req  = 1'b0;
    run_edges(6);
    chk_cnt++;
    if (stage_rst_n !== 3'b111) $display("FAIL zero_mask_stage got=%b required=111", stage_rst_n);
    else pass_cnt++;
    chk_cnt++;
    if (dbg_state !== RUN) $display("FAIL zero_mask_state got=%0d required=%0d", dbg_state, RUN);
    else pass_cnt++;
    // A request during RELEASE must not disturb the power-up timeline.
    do_reset();
    push_powerup(0);
    run_edges(15);
    soft_rst_req  = 1'b1;
    soft_rst_mask = 3'b111;
    run_edges(1);
    soft_rst_req  = 1'b0;
    soft_rst_mask = '0;
    run_edges(10);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL release_req_missing got=%0d pending required=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
    chk_cnt++;
    if (seq_done !== 1'b1) $display("FAIL release_req_done got=%b required=1", seq_done);
    else pass_cnt++;
  endtask

  task automatic test_lock_loss();
    edge_cnt = 0;
    exp_q.push_back(mk_ev(3, 3'b000, 1'b0, 1'b1));
    dcm_locked = 1'b0;
    run_edges(5);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL lock_loss_missing got=%0d pending required=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
    edge_cnt = 0;
    dcm_locked = 1'b1;
    push_powerup(0);
    run_edges(26);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL relock_missing got=%0d pending required=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_lock_glitch();
    // One low sample at edge 8 after counts at edges 3..7; filter restarts at edge 9,
    // so RELEASE begins at edge 16 instead of 10.
    do_reset();
    push_powerup(6);
    run_edges(5);
    dcm_locked = 1'b0;
    run_edges(1);
    dcm_locked = 1'b1;
    run_edges(26);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL glitch_missing got=%0d pending required=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    do_reset();
    exp_q.push_back(mk_ev(LF + 2 + SD, 3'b001, 1'b0, 1'b1));
    run_edges(16);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL async_pre_missing got=%0d pending required=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
    rst = 1'b1;
    #2;
    chk_cnt++;
    if ({stage_rst_n, seq_done, busy} !== 5'b00001)
      $display("FAIL async_outputs got=%b required=00001", {stage_rst_n, seq_done, busy});
    else pass_cnt++;
    chk_cnt++;
    if (dbg_state !== HOLD) $display("FAIL async_state got=%0d required=%0d", dbg_state, HOLD);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    edge_cnt = 0;
    prev_obs = 5'b00001;
    push_powerup(0);
    run_edges(26);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL async_post_missing got=%0d pending required=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_soft_reset();
    test_soft_ignored();
    test_lock_loss();
    test_lock_glitch();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
